odt_host_port: RTL and testbench

Host-side endpoint of the byte-wide ODT console channel: the far end of the `rrdy/rstb/wrdy/wstb/ad` handshake driven by the DCJ11 bus bridge. It receives console bytes that the PDP-11 writes to XBUF and delivers them to the host on a valid/ready stream. It also takes host keystrokes from a stream and presents them on `ad` for the bridge to latch into RBUF. Each direction is buffered by a small FIFO. This block sits in the host/Apple II-side logic, one clock domain, opposite the bridge's `ad` pins.

---
 rtl/odt_host_port.sv | 221 ++++++++++++++++++++++
 tb/tb_odt_host_port.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odt_host_port.sv
`default_nettype none
// ============================================================================
// Module   : odt_host_port
// Purpose  : Host-side endpoint of the byte-wide ODT console channel. Accepts
//            console bytes from the bus bridge (rrdy/rstb handshake) into an
//            RX FIFO delivered on a valid/ready stream, and presents host
//            keystrokes from a TX FIFO on the shared ad pads (wrdy/wstb).
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            rrdy/rstb, ad_i       - bridge->host byte handshake and pad input
//            wrdy/wstb, ad_o/ad_oe - host->bridge byte handshake and pad drive
//            tx_data/valid/ready   - host keystroke stream in
//            rx_data/valid/ready   - console byte stream out
//            tx_level, rx_level    - FIFO occupancy
//            err_collision         - sticky: bridge strobed while host drove ad
// Revision : 1.0 - initial release
// ============================================================================
module odt_host_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          rrdy,
  input  logic                          rstb,
  output logic                          wrdy,
  input  logic                          wstb,
  input  logic [7:0]                    ad_i,
  output logic [7:0]                    ad_o,
  output logic                          ad_oe,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          err_collision
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_lw = c_aw + 1;
  localparam int c_cw = (SETUP > 1) ? $clog2(SETUP) : 1;
  localparam logic [c_lw-1:0] c_full = c_lw'(FIFO_DEPTH);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_READY = 2'd1, R_WAIT = 2'd2} rx_state_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_SETUP = 2'd1, T_REQ = 2'd2, T_HOLD = 2'd3} tx_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;

  logic r_rstb_m, r_rstb_s, r_wstb_m, r_wstb_s;

  logic [7:0]      r_tx_mem [FIFO_DEPTH];
  logic [7:0]      r_rx_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [c_lw-1:0] r_tx_cnt, r_rx_cnt;

  logic            r_drive;
  logic [7:0]      r_ad_o;
  logic [c_cw-1:0] r_setup_cnt;
  logic            r_err;

  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_start;

  assign w_tx_full  = (r_tx_cnt == c_full);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == c_full);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_tx_push  = tx_valid & ~w_tx_full;
  assign w_rx_pop   = rx_ready & ~w_rx_empty;

  assign tx_ready      = ~w_tx_full;
  assign rx_valid      = ~w_rx_empty;
  assign rx_data       = r_rx_mem[r_rx_rp];
  assign tx_level      = r_tx_cnt;
  assign rx_level      = r_rx_cnt;
  assign rrdy          = (r_rx_state == R_READY);
  assign wrdy          = (r_tx_state == T_REQ);
  assign ad_o          = r_ad_o;
  // The raw strobe releases the pads immediately, ahead of the synchronizer,
  // so the bridge never fights our drive.
  assign ad_oe         = r_drive & ~rstb;
  assign err_collision = r_err;

  // --------------------------------------------------------------------------
  // Next-state logic for both handshake FSMs
  // --------------------------------------------------------------------------
  always_comb begin
    w_tx_next  = r_tx_state;
    w_rx_next  = r_rx_state;
    w_tx_start = 1'b0;
    w_tx_pop   = 1'b0;
    w_rx_push  = 1'b0;

    case (r_tx_state)
      T_IDLE: begin
        if (!w_tx_empty && !r_rstb_s && (r_rx_state != R_WAIT)) begin
          w_tx_start = 1'b1;
          w_tx_next  = T_SETUP;
        end
      end
      T_SETUP: begin
        if (r_setup_cnt == c_cw'(SETUP - 1)) begin
          w_tx_next = T_REQ;
        end
      end
      T_REQ: begin
        if (r_wstb_s) begin
          w_tx_next = T_HOLD;
        end
      end
      T_HOLD: begin
        if (!r_wstb_s) begin
          w_tx_pop  = 1'b1;
          w_tx_next = T_IDLE;
        end
      end
      default: w_tx_next = T_IDLE;
    endcase

    case (r_rx_state)
      R_IDLE: begin
        // A starting TX exchange wins the pads over offering rrdy.
        if (!w_rx_full && (r_tx_state == T_IDLE) && !w_tx_start && !r_rstb_s) begin
          w_rx_next = R_READY;
        end
      end
      R_READY: begin
        if (r_rstb_s) begin
          w_rx_push = 1'b1;
          w_rx_next = R_WAIT;
        end else if ((r_tx_state != T_IDLE) || w_tx_start) begin
          // Withdraw rrdy on the same edge the TX exchange begins driving ad.
          w_rx_next = R_IDLE;
        end
      end
      R_WAIT: begin
        if (!r_rstb_s) begin
          w_rx_next = R_IDLE;
        end
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, synchronizers, FIFO pointers and pad drive
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state  <= R_IDLE;
      r_tx_state  <= T_IDLE;
      r_rstb_m    <= 1'b0;
      r_rstb_s    <= 1'b0;
      r_wstb_m    <= 1'b0;
      r_wstb_s    <= 1'b0;
      r_tx_wp     <= '0;
      r_tx_rp     <= '0;
      r_tx_cnt    <= '0;
      r_rx_wp     <= '0;
      r_rx_rp     <= '0;
      r_rx_cnt    <= '0;
      r_drive     <= 1'b0;
      r_ad_o      <= 8'h00;
      r_setup_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_tx_state <= w_tx_next;

      r_rstb_m   <= rstb;
      r_rstb_s   <= r_rstb_m;
      r_wstb_m   <= wstb;
      r_wstb_s   <= r_wstb_m;

      if (w_tx_push) r_tx_wp <= r_tx_wp + c_aw'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_aw'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_lw'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - c_lw'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase

      if (w_rx_push) r_rx_wp <= r_rx_wp + c_aw'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_aw'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_lw'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - c_lw'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase

      // The head byte is captured once at exchange start; it cannot change
      // until the pop that ends the exchange.
      if (w_tx_start) begin
        r_drive <= 1'b1;
        r_ad_o  <= r_tx_mem[r_tx_rp];
      end else if (w_tx_pop) begin
        r_drive <= 1'b0;
      end

      if (r_tx_state == T_SETUP) r_setup_cnt <= r_setup_cnt + c_cw'(1);
      else                       r_setup_cnt <= '0;

      if (r_rstb_s && (r_rx_state != R_READY) && (r_rx_state != R_WAIT)) begin
        r_err <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= ad_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_odt_host_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_odt_host_port
// Purpose  : Self-checking bench for odt_host_port. Bridge and host models
//            drive directed byte sequences; a scoreboard of expected bytes
//            per direction plus per-cycle protocol rules check the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odt_host_port;

  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rstb = 1'b0;
  logic          wstb = 1'b0;
  logic [7:0]    ad_i = 8'h00;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          rx_ready = 1'b0;
  logic          rrdy, wrdy, ad_oe, tx_ready, rx_valid, err_collision;
  logic [7:0]    ad_o, rx_data;
  logic [LW-1:0] tx_level, rx_level;

  odt_host_port #(.FIFO_DEPTH(DEPTH), .SETUP(SETUP)) dut (
    .clk(clk), .rst_n(rst_n),
    .rrdy(rrdy), .rstb(rstb), .wrdy(wrdy), .wstb(wstb),
    .ad_i(ad_i), .ad_o(ad_o), .ad_oe(ad_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level),
    .err_collision(err_collision)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit mon_en = 1'b0;
  bit watch_coll = 1'b0;
  int rx_pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Host keystroke: offer a byte and hold tx_valid until it is taken.
  task automatic host_push(input logic [7:0] b);
    int k = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && k < 300) begin cyc(); k++; end
    chk("tx_accept", tx_ready, 1);
    if (tx_ready) txq.push_back(b);
    cyc();
    tx_valid = 1'b0;
  endtask

  // Bridge writing a console byte: strobe once rrdy is offered, release once
  // the host withdraws rrdy.
  task automatic bridge_rx_send(input logic [7:0] b);
    int k = 0;
    while (!rrdy && k < 300) begin cyc(); k++; end
    chk("rx_rrdy_offer", rrdy, 1);
    ad_i = b;
    rstb = 1'b1;
    k = 0;
    while (rrdy && k < 50) begin cyc(); k++; end
    chk("rx_rrdy_taken", rrdy, 0);
    rxq.push_back(b);
    cyc();
    rstb = 1'b0;
  endtask

  // Bridge fetching a keystroke: strobe on wrdy, release 3 cycles after wrdy
  // drops and latch ad on that edge.
  task automatic bridge_tx_serve(input bit timed);
    int k = 0;
    logic [7:0] exp;
    while (!wrdy && k < 300) begin cyc(); k++; end
    chk("tx_wrdy_offer", wrdy, 1);
    wstb = 1'b1;
    k = 0;
    while (wrdy && k < 50) begin cyc(); k++; end
    if (timed) chk("tx_wrdy_fall_latency", k, 3);
    cyc(); cyc(); cyc();
    chk("tx_ad_oe_at_latch", ad_oe, 1);
    if (txq.size() == 0) chk("tx_unexpected_byte", 1, 0);
    else begin
      exp = txq.pop_front();
      chk("tx_byte", ad_o, exp);
    end
    wstb = 1'b0;
    cyc(); cyc();
    if (timed) chk("tx_ad_oe_hold", ad_oe, 1);
    cyc();
    chk("tx_ad_oe_release", ad_oe, 0);
  endtask

  // Per-cycle protocol rules and RX scoreboard.
  logic prev_err = 1'b0;
  logic prev_wrdy = 1'b0;
  int   drv_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rule_rx_valid_nonempty", rx_valid, (rx_level != 0));
      chk("rule_tx_ready_notfull", tx_ready, (tx_level != DEPTH));
      chk("rule_rrdy_wrdy_exclusive", rrdy & wrdy, 0);
      if (rstb) chk("rule_oe_off_under_rstb", ad_oe, 0);
      if (wrdy && !rstb) chk("rule_wrdy_while_driven", ad_oe, 1);
      if (prev_err && rst_n) chk("rule_err_sticky", err_collision, 1);
      if (watch_coll) chk("coll_rrdy_low", rrdy, 0);
      if (wrdy && !prev_wrdy && !watch_coll) chk("tx_setup_cycles_ok", drv_cnt >= SETUP, 1);
      if (rx_valid && rx_ready) begin
        rx_pops++;
        if (rxq.size() == 0) chk("rx_unexpected_byte", 1, 0);
        else chk("rx_byte_order", rx_data, rxq.pop_front());
      end
    end
    prev_err  = rst_n ? err_collision : 1'b0;
    prev_wrdy = wrdy;
    if (ad_oe && !wrdy) drv_cnt++;
    else if (!ad_oe)    drv_cnt = 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pops0;

    // ---------------- reset values ----------------
    repeat (3) cyc();
    chk("reset_rrdy", rrdy, 0);
    chk("reset_wrdy", wrdy, 0);
    chk("reset_ad_oe", ad_oe, 0);
    chk("reset_ad_o", ad_o, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_err", err_collision, 0);
    chk("reset_tx_level", tx_level, 0);
    chk("reset_rx_level", rx_level, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    rx_ready = 1'b1;
    cyc();
    chk("post_reset_tx_ready", tx_ready, 1);

    // ---------------- reset during T_REQ ----------------
    host_push(8'h55);
    k = 0;
    while (!wrdy && k < 50) begin cyc(); k++; end
    chk("mid_reset_reached_req", wrdy, 1);
    rst_n = 1'b0;
    cyc();
    chk("mid_reset_wrdy", wrdy, 0);
    chk("mid_reset_ad_oe", ad_oe, 0);
    chk("mid_reset_tx_level", tx_level, 0);
    chk("mid_reset_rx_level", rx_level, 0);
    txq.delete();
    rst_n = 1'b1;
    host_push(8'h66);
    chk("mid_reset_next_accepted", tx_level, 1);
    bridge_tx_serve(1'b0);

    // ---------------- RX single byte ----------------
    rx_ready = 1'b0;
    k = 0;
    while (!rrdy && k < 50) begin cyc(); k++; end
    chk("rx1_rrdy_offered", rrdy, 1);
    ad_i = 8'h41;
    rstb = 1'b1;
    cyc();
    chk("rx1_rrdy_c1", rrdy, 1);
    cyc();
    chk("rx1_rrdy_c2", rrdy, 1);
    cyc();
    chk("rx1_rrdy_fell", rrdy, 0);
    chk("rx1_rx_valid", rx_valid, 1);
    chk("rx1_rx_data", rx_data, 8'h41);
    chk("rx1_rx_level", rx_level, 1);
    rxq.push_back(8'h41);
    repeat (3) cyc();
    chk("rx1_rrdy_held_low", rrdy, 0);
    rstb = 1'b0;
    repeat (3) cyc();
    chk("rx1_rrdy_still_low", rrdy, 0);
    cyc();
    chk("rx1_rrdy_returns", rrdy, 1);
    rx_ready = 1'b1;
    cyc();
    chk("rx1_drained", rx_level, 0);
    chk("rx1_scoreboard_empty", rxq.size(), 0);

    // ---------------- TX single byte ----------------
    host_push(8'h0D);
    chk("tx1_level_after_push", tx_level, 1);
    cyc();
    chk("tx1_ad_oe_setup", ad_oe, 1);
    chk("tx1_rrdy_withdrawn", rrdy, 0);
    chk("tx1_wrdy_setup", wrdy, 0);
    cyc();
    chk("tx1_wrdy_setup2", wrdy, 0);
    cyc();
    chk("tx1_wrdy_rise", wrdy, 1);
    chk("tx1_ad_o", ad_o, 8'h0D);
    bridge_tx_serve(1'b1);
    chk("tx1_level_done", tx_level, 0);
    chk("tx1_no_collision", err_collision, 0);

    // ---------------- RX back-pressure ----------------
    rx_ready = 1'b0;
    pops0 = rx_pops;
    for (int i = 0; i < 4; i++) bridge_rx_send(8'h31 + 8'(i));
    chk("bp_level_full", rx_level, 4);
    repeat (20) cyc();
    chk("bp_rrdy_stuck", rrdy, 0);
    chk("bp_level_held", rx_level, 4);
    fork
      bridge_rx_send(8'h35);
      begin cyc(); rx_ready = 1'b1; end
    join
    k = 0;
    while ((rx_level != 0 || rxq.size() != 0) && k < 100) begin cyc(); k++; end
    chk("bp_drained", rx_level, 0);
    chk("bp_pop_count", rx_pops - pops0, 5);

    // ---------------- TX burst with pointer wrap ----------------
    for (int i = 0; i < 4; i++) host_push(8'h10 + 8'(i));
    repeat (5) cyc();
    chk("burst_level_full", tx_level, 4);
    chk("burst_tx_ready_low", tx_ready, 0);
    fork
      begin host_push(8'h14); host_push(8'h15); end
      begin for (int i = 0; i < 6; i++) bridge_tx_serve(1'b0); end
    join
    chk("burst_level_done", tx_level, 0);
    chk("burst_scoreboard_empty", txq.size(), 0);

    // ---------------- collision during T_SETUP ----------------
    repeat (4) cyc();
    host_push(8'h7E);
    cyc();
    chk("coll_in_setup", ad_oe, 1);
    watch_coll = 1'b1;
    rstb = 1'b1;
    #1;
    chk("coll_oe_drop", ad_oe, 0);
    repeat (4) cyc();
    chk("coll_err_set", err_collision, 1);
    chk("coll_rx_level", rx_level, 0);
    rstb = 1'b0;
    bridge_tx_serve(1'b0);
    watch_coll = 1'b0;
    repeat (5) cyc();
    chk("coll_err_sticky", err_collision, 1);
    chk("coll_tx_done", tx_level, 0);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
